// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline types for the OTTER front end: stall-controller states,
// the canonical NOP encoding and the IF/ID register payload.
package otter_pipe_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam int          STALL_CNT_W  = 4;
  localparam int          SQUASH_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } stall_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Fetch/decode handshake between the pipeline datapath (master) and the
// stall controller (slave).
interface pipeline_stall_ctrl_if;

  logic        stall;
  logic        branch_taken;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        pc_write;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic        stall_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  modport master (
    output stall, branch_taken, if_pc, if_instr, if_valid,
    input  pc_write, if_id_pc, if_id_instr, if_id_valid, id_ex_bubble,
           stall_err, stall_cycles, flush_cycles
  );

  modport slave (
    input  stall, branch_taken, if_pc, if_instr, if_valid,
    output pc_write, if_id_pc, if_id_instr, if_id_valid, id_ex_bubble,
           stall_err, stall_cycles, flush_cycles
  );

endinterface

// File: rtl/pipeline_stall_ctrl_if_id_reg.sv
// IF/ID pipeline register: holds when en=0, loads a NOP marked invalid when
// flush=1, otherwise captures the fetched PC/instruction as valid.
module if_id_reg
  import otter_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = otter_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output if_id_t      q
);

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};
        end else if (en) begin
            if (flush) q <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
            else       q <= '{pc: pc, instr: instr, valid: 1'b1};
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Load-use stall / branch-squash controller owning the IF/ID register.
// Define STALL_CTRL_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_stall_ctrl
  import otter_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR    = otter_pipe_pkg::NOP_INSTR,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 4
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_stall_ctrl_if.slave  bus
);

    stall_state_t            state;
    logic [STALL_CNT_W-1:0]  stall_cnt;
    logic [STALL_CNT_W-1:0]  stall_cnt_inc;
    logic [SQUASH_CNT_W-1:0] squash_cnt;
    logic                    squash_active;
    logic                    stall_err;
    logic                    pc_write;
    logic                    id_ex_bubble;
    logic                    reg_en;
    logic                    reg_flush;
    if_id_t                  if_id_q;

    // A nonzero squash count means the word at the imem output is wrong-path,
    // including the release cycle of a stall that interrupted FLUSH.
    assign squash_active = (squash_cnt != '0);
    assign stall_cnt_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        pc_write     = 1'b0;
        id_ex_bubble = 1'b1;
        reg_en       = 1'b0;
        reg_flush    = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            pc_write     = 1'b1;
            id_ex_bubble = 1'b1;
            reg_en       = 1'b1;
            reg_flush    = 1'b1;
        end else if (bus.stall) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (squash_active) begin
            pc_write     = bus.if_valid;
            id_ex_bubble = 1'b0;
            reg_en       = 1'b1;
            reg_flush    = 1'b1;
        end else if (!bus.if_valid) begin
            id_ex_bubble = 1'b0;
            reg_en       = 1'b1;
            reg_flush    = 1'b1;
        end else begin
            pc_write     = 1'b1;
            id_ex_bubble = 1'b0;
            reg_en       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            squash_cnt <= '0;
            stall_cnt  <= '0;
            stall_err  <= 1'b0;
        end else if (bus.branch_taken) begin
            state      <= FLUSH;
            squash_cnt <= SQUASH_CNT_W'(FLUSH_CYCLES);
            stall_cnt  <= '0;
        end else if (bus.stall) begin
            state     <= STALL;
            stall_cnt <= stall_cnt_inc;
            if (stall_cnt_inc >= STALL_CNT_W'(MAX_STALL)) stall_err <= 1'b1;
        end else begin
            stall_cnt <= '0;
            if (!squash_active) begin
                state <= RUN;
            end else if (bus.if_valid) begin
                squash_cnt <= squash_cnt - 1'b1;
                state      <= (squash_cnt == SQUASH_CNT_W'(1)) ? RUN : FLUSH;
            end else begin
                state <= FLUSH;
            end
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (reg_en),
        .flush (reg_flush),
        .pc    (bus.if_pc),
        .instr (bus.if_instr),
        .q     (if_id_q)
    );

`ifdef STALL_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            if (bus.stall && !bus.branch_taken)     stall_cycles_q <= stall_cycles_q + 32'd1;
            if (state == FLUSH || bus.branch_taken) flush_cycles_q <= flush_cycles_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_cycles = flush_cycles_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_cycles = 32'd0;
`endif

    assign bus.pc_write     = pc_write;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.stall_err    = stall_err;
    assign bus.if_id_pc     = if_id_q.pc;
    assign bus.if_id_instr  = if_id_q.instr;
    assign bus.if_id_valid  = if_id_q.valid;

endmodule
